// File: rtl/bus_burst_ctrl.sv
// Burst read/write bus master between the CPU core and the BUS_* handshake interface.
// Defining BUS_TIMEOUT_EN adds a per-beat watchdog that aborts a stalled beat and flags err.
module bus_burst_ctrl #(
    parameter int  ADDR_W      = 32,
    parameter int  DATA_W      = 32,
    parameter int  MAX_BURST   = 16,
    parameter int  TIMEOUT_CYC = 255,
    localparam int LEN_W       = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_wnext,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] BUS_addr,
    output logic [DATA_W-1:0] BUS_wdata,
    input  logic [DATA_W-1:0] BUS_rdata,
    output logic              BUS_valid,
    input  logic              BUS_wready,
    output logic              BUS_rready,
    input  logic              BUS_rvalid,
    output logic              BUS_mode
);

    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

    generate
        if ((DATA_W % 8) != 0 || MAX_BURST < 2 || (MAX_BURST & (MAX_BURST - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
            $error("bus_burst_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WBEAT, S_RBEAT, S_FIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_mode;
    logic              r_rvalid;
    logic              w_accept;
    logic              w_active;
    logic              w_beat;
    logic              w_last;
    logic              w_timeout;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_active = (r_state == S_WBEAT) || (r_state == S_RBEAT);
    assign w_beat   = ((r_state == S_WBEAT) && BUS_wready) || ((r_state == S_RBEAT) && BUS_rvalid);
    assign w_last   = (r_cnt == '0);

`ifdef BUS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_err;

    // The cycle the counter would reach TIMEOUT_CYC is the abort cycle itself.
    assign w_timeout = w_active && !w_beat && (r_wdog == WD_W'(TIMEOUT_CYC - 1));
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (!w_active || w_beat) r_wdog <= '0;
            else                     r_wdog <= r_wdog + WD_W'(1);
            if (w_accept)            r_err  <= 1'b0;
            else if (w_timeout)      r_err  <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:           if (start) w_next = mode ? S_WBEAT : S_RBEAT;
            S_WBEAT, S_RBEAT: if ((w_beat && w_last) || w_timeout) w_next = S_FIN;
            S_FIN:            w_next = S_IDLE;
            default:          w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_accept) begin
                r_mode  <= mode;
                r_addr  <= addr;
                r_wdata <= core_wdata;
                r_cnt   <= len;
            end else if (w_beat) begin
                r_addr <= r_addr + BEAT_BYTES;
                r_cnt  <= r_cnt - LEN_W'(1);
                if (r_state == S_WBEAT) begin
                    r_wdata <= core_wdata;
                end else begin
                    r_rdata  <= BUS_rdata;
                    r_rvalid <= 1'b1;
                end
            end
        end
    end

    // Handshake outputs decode straight from the state register so reset clears them at once.
    assign BUS_valid   = w_active;
    assign BUS_rready  = (r_state == S_RBEAT);
    assign BUS_mode    = r_mode;
    assign BUS_addr    = r_addr;
    assign BUS_wdata   = r_wdata;
    assign core_wnext  = (r_state == S_WBEAT) && BUS_wready;
    assign core_rdata  = r_rdata;
    assign core_rvalid = r_rvalid;
    assign done        = (r_state == S_FIN);
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_burst_ctrl.sv
// Directed bench for bus_burst_ctrl: vector table for single write and 4-beat read,
// hand-written sequences for wrap, back-to-back starts, async reset and the watchdog.
module tb_bus_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  len = '0;
    logic [31:0] core_wdata = '0;
    logic        core_wnext;
    logic [31:0] core_rdata;
    logic        core_rvalid;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] BUS_addr;
    logic [31:0] BUS_wdata;
    logic [31:0] BUS_rdata = '0;
    logic        BUS_valid;
    logic        BUS_wready = 1'b0;
    logic        BUS_rready;
    logic        BUS_rvalid = 1'b0;
    logic        BUS_mode;

    int n_checks = 0;
    int n_errors = 0;

    bus_burst_ctrl #(
        .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .addr(addr), .len(len),
        .core_wdata(core_wdata), .core_wnext(core_wnext), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid), .done(done), .err(err), .busy(busy),
        .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata), .BUS_rdata(BUS_rdata),
        .BUS_valid(BUS_valid), .BUS_wready(BUS_wready), .BUS_rready(BUS_rready),
        .BUS_rvalid(BUS_rvalid), .BUS_mode(BUS_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        st;
        logic        md;
        logic [31:0] a;
        logic [3:0]  l;
        logic [31:0] wd;
        logic        wr;
        logic        rv;
        logic [31:0] rd;
        logic        e_valid;
        logic        e_mode;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_wnext;
        logic        e_rready;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic cyc(input logic st, input logic md, input logic [31:0] a, input logic [3:0] l,
                       input logic [31:0] wd, input logic wr, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        start = st; mode = md; addr = a; len = l; core_wdata = wd;
        BUS_wready = wr; BUS_rvalid = rv; BUS_rdata = rd;
        #1;
    endtask

    function automatic logic [31:0] ctl();
        return 32'({BUS_valid, BUS_rready, core_wnext, core_rvalid, done, busy, err});
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        // single write, BUS_wready two cycles after BUS_valid rises; stray rvalid ignored
        vq.push_back('{1'b1,1'b1,32'h100,4'd0,32'hDEADBEEF,1'b0,1'b0,32'h0,  1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'hDEADBEEF,1'b0,1'b0,32'h0,    1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'hDEADBEEF,1'b0,1'b1,32'h99,   1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,1'b0,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'hDEADBEEF,1'b1,1'b0,32'h0,    1'b1,1'b1,32'h100,32'hDEADBEEF,1'b1,1'b0,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'hDEADBEEF,1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'hDEADBEEF,1'b1,1'b1,32'h77,   1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0});
        // 4-beat read with one idle cycle between returned words; stray wready ignored
        vq.push_back('{1'b1,1'b0,32'h200,4'd3,32'h0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b1,1'b0,32'h0,           1'b1,1'b0,32'h200,32'h0,1'b0,1'b1,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b1,32'h11,          1'b1,1'b0,32'h200,32'h0,1'b0,1'b1,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b0,32'h0,           1'b1,1'b0,32'h204,32'h0,1'b0,1'b1,1'b1,32'h11,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b1,32'h22,          1'b1,1'b0,32'h204,32'h0,1'b0,1'b1,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b0,32'h0,           1'b1,1'b0,32'h208,32'h0,1'b0,1'b1,1'b1,32'h22,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b1,32'h33,          1'b1,1'b0,32'h208,32'h0,1'b0,1'b1,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b0,32'h0,           1'b1,1'b0,32'h20C,32'h0,1'b0,1'b1,1'b1,32'h33,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b1,32'h44,          1'b1,1'b0,32'h20C,32'h0,1'b0,1'b1,1'b0,32'h0,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b0,32'h0,           1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b1,32'h44,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,32'h0,4'd0,32'h0,1'b0,1'b0,32'h0,           1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h0,1'b0,1'b0});

        // reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ctrl", ctl(), 32'h0);
        chk("rst_mode", 32'(BUS_mode), 32'h0);
        chk("rst_addr", BUS_addr, 32'h0);
        chk("rst_wdata", BUS_wdata, 32'h0);
        chk("rst_rdata", core_rdata, 32'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].st, vq[i].md, vq[i].a, vq[i].l, vq[i].wd, vq[i].wr, vq[i].rv, vq[i].rd);
            chk($sformatf("vec%0d_ctrl", i), ctl(),
                32'({vq[i].e_valid, vq[i].e_rready, vq[i].e_wnext, vq[i].e_rvalid, vq[i].e_done, vq[i].e_busy, 1'b0}));
            if (vq[i].e_valid) begin
                chk($sformatf("vec%0d_mode", i), 32'(BUS_mode), 32'(vq[i].e_mode));
                chk($sformatf("vec%0d_addr", i), BUS_addr, vq[i].e_addr);
                if (vq[i].e_mode) chk($sformatf("vec%0d_wdata", i), BUS_wdata, vq[i].e_wdata);
            end
            if (vq[i].e_rvalid) chk($sformatf("vec%0d_rdata", i), core_rdata, vq[i].e_rdata);
        end

        // address wrap, 2-beat write, slave always ready; core shows word B right after start
        cyc(1'b1, 1'b1, 32'hFFFFFFFC, 4'd1, 32'hA0A0A0A0, 1'b1, 1'b0, 32'h0);
        chk("wrap_idle", ctl(), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'hB1B1B1B1, 1'b1, 1'b0, 32'h0);
        chk("wrap_b0_ctrl", ctl(), 32'b1010010);
        chk("wrap_b0_addr", BUS_addr, 32'hFFFFFFFC);
        chk("wrap_b0_wdata", BUS_wdata, 32'hA0A0A0A0);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'hC2C2C2C2, 1'b1, 1'b0, 32'h0);
        chk("wrap_b1_ctrl", ctl(), 32'b1010010);
        chk("wrap_b1_addr", BUS_addr, 32'h00000000);
        chk("wrap_b1_wdata", BUS_wdata, 32'hB1B1B1B1);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_done", ctl(), 32'b0000110);

        // back-to-back: start while busy ignored, start the cycle after done accepted
        cyc(1'b1, 1'b0, 32'h300, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h400, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("b2b_busy_mode", 32'(BUS_mode), 32'h0);
        chk("b2b_busy_addr", BUS_addr, 32'h300);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b1, 32'h55);
        chk("b2b_rbeat", ctl(), 32'b1100010);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("b2b_done", ctl(), 32'b0001110);
        chk("b2b_rdata", core_rdata, 32'h55);
        cyc(1'b1, 1'b1, 32'h500, 4'd0, 32'h77, 1'b0, 1'b0, 32'h0);
        chk("b2b_idle", ctl(), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h77, 1'b0, 1'b0, 32'h0);
        chk("b2b_2nd_ctrl", ctl(), 32'b1000010);
        chk("b2b_2nd_addr", BUS_addr, 32'h500);
        chk("b2b_2nd_mode", 32'(BUS_mode), 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h77, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("b2b_2nd_done", ctl(), 32'b0000110);

        // async reset between edges while beat 2 of a 4-beat read is pending
        cyc(1'b1, 1'b0, 32'h600, 4'd3, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b1, 32'hAA);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("arst_pre_addr", BUS_addr, 32'h604);
        chk("arst_pre_ctrl", ctl(), 32'b1101010);
        #2 rst = 1'b1;
        #1;
        chk("arst_now", 32'({BUS_valid, BUS_rready, busy, done}), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk($sformatf("arst_hold%0d", i), ctl(), 32'h0);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("arst_idle", ctl(), 32'h0);
        cyc(1'b1, 1'b1, 32'h800, 4'd0, 32'h12345678, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("arst_after_ctrl", ctl(), 32'b1010010);
        chk("arst_after_addr", BUS_addr, 32'h800);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("arst_after_done", ctl(), 32'b0000110);

`ifdef BUS_TIMEOUT_EN
        // watchdog: 8 stalled cycles abort the write
        cyc(1'b1, 1'b1, 32'h700, 4'd0, 32'h1234, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk($sformatf("wdog_stall%0d", k), ctl(), 32'b1000010);
        end
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wdog_done", ctl(), 32'b0000111);
        cyc(1'b1, 1'b0, 32'h900, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wdog_err_sticky", ctl(), 32'b0000001);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wdog_err_clr", ctl(), 32'b1100010);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b1, 32'h5A);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wdog_next_done", ctl(), 32'b0001110);
        chk("wdog_next_rdata", core_rdata, 32'h5A);
`else
        // no watchdog: a long stall never aborts
        cyc(1'b1, 1'b1, 32'h700, 4'd0, 32'h1234, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk($sformatf("stall%0d", k), ctl(), 32'b1000010);
        end
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("stall_release", ctl(), 32'b1010010);
        chk("stall_wdata", BUS_wdata, 32'h1234);
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("stall_done", ctl(), 32'b0000110);
`endif
        cyc(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("final_idle", ctl(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
